// File: rtl/pc_fetch_unit.sv
// Instruction-fetch front end: owns the PC, runs the imem req/ack handshake and
// hands one instruction at a time to decode, honouring redirects from the PC-source mux.
module pc_fetch_unit #(
    parameter int               WIDTH        = 16,
    parameter logic [WIDTH-1:0] RESET_VECTOR = 16'h0000
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_data,
    output logic             if_valid,
    input  logic             if_ready,
    output logic [WIDTH-1:0] if_instr,
    output logic [WIDTH-1:0] if_pc,
    input  logic             redirect,
    input  logic [1:0]       pc_src,
    input  logic [WIDTH-1:0] redirect_pc,
    input  logic [WIDTH-1:0] br_offset,
    input  logic [11:0]      j_target,
    input  logic [WIDTH-1:0] jr_addr
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] pc, pc_next;
    logic [WIDTH-1:0] pend_target, pend_target_next;
    logic             squash_pending, squash_pending_next;
    logic [WIDTH-1:0] instr_next, ifpc_next;
    logic [WIDTH-1:0] target;

    function automatic logic [WIDTH-1:0] calc_target(
        input logic [1:0]       src,
        input logic [WIDTH-1:0] rpc,
        input logic [WIDTH-1:0] offset,
        input logic [11:0]      jfield,
        input logic [WIDTH-1:0] jreg
    );
        logic [WIDTH-1:0] base;
        base = rpc + 1'b1;
        case (src)
            2'b00:   calc_target = base;
            2'b01:   calc_target = base + offset;
            2'b10:   calc_target = {base[WIDTH-1:12], jfield};
            default: calc_target = jreg;
        endcase
    endfunction

    assign target = calc_target(pc_src, redirect_pc, br_offset, j_target, jr_addr);

    // Moore outputs: nothing below depends combinationally on an input
    assign imem_req  = (state == FETCH);
    assign if_valid  = (state == VALID);
    assign imem_addr = pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= BOOT;
            pc             <= RESET_VECTOR;
            pend_target    <= '0;
            squash_pending <= 1'b0;
            if_instr       <= '0;
            if_pc          <= '0;
        end else begin
            state          <= state_next;
            pc             <= pc_next;
            pend_target    <= pend_target_next;
            squash_pending <= squash_pending_next;
            if_instr       <= instr_next;
            if_pc          <= ifpc_next;
        end
    end

    always_comb begin
        state_next          = state;
        pc_next             = pc;
        pend_target_next    = pend_target;
        squash_pending_next = squash_pending;
        instr_next          = if_instr;
        ifpc_next           = if_pc;

        case (state)
            BOOT: begin
                state_next = FETCH;
            end
            FETCH: begin
                if (imem_ack) begin
                    if (redirect) begin
                        pc_next             = target;
                        squash_pending_next = 1'b0;
                    end else if (squash_pending) begin
                        pc_next             = pend_target;
                        squash_pending_next = 1'b0;
                    end else begin
                        instr_next = imem_data;
                        ifpc_next  = pc;
                        pc_next    = pc + 1'b1;
                        state_next = VALID;
                    end
                end else if (redirect) begin
                    // Address must stay stable until the ack; remember where to go instead
                    pend_target_next    = target;
                    squash_pending_next = 1'b1;
                end
            end
            VALID: begin
                if (redirect) begin
                    pc_next    = target;
                    state_next = FETCH;
                end else if (if_ready) begin
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed test-plan scenarios plus randomized traffic
// checked every cycle against a transaction-level reference model.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic        if_valid;
    logic        if_ready;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic        redirect;
    logic [1:0]  pc_src;
    logic [15:0] redirect_pc;
    logic [15:0] br_offset;
    logic [11:0] j_target;
    logic [15:0] jr_addr;

    int n_checks = 0;
    int n_fails  = 0;

    pc_fetch_unit #(.WIDTH(16), .RESET_VECTOR(16'h0000)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data),
        .if_valid(if_valid), .if_ready(if_ready),
        .if_instr(if_instr), .if_pc(if_pc),
        .redirect(redirect), .pc_src(pc_src), .redirect_pc(redirect_pc),
        .br_offset(br_offset), .j_target(j_target), .jr_addr(jr_addr)
    );

    always #5 clk = ~clk;

    // Reference model: a PC, an optional deferred target, a boot flag and a
    // holding buffer (queue of at most one fetched instruction).
    typedef struct {
        logic [15:0] pc;
        logic [15:0] instr;
    } pkt_t;

    logic [15:0] m_pc;
    logic [15:0] m_pend;
    bit          m_sq;
    bit          m_boot;
    pkt_t        m_buf[$];
    logic [15:0] seen_pc[$];
    logic [15:0] seen_instr[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] m_target();
        int base;
        int res;
        base = (int'(redirect_pc) + 1) % 65536;
        case (pc_src)
            2'd0:    res = base;
            2'd1:    res = (base + int'(br_offset)) % 65536;
            2'd2:    res = (base / 4096) * 4096 + int'(j_target);
            default: res = int'(jr_addr);
        endcase
        return 16'(res);
    endfunction

    function automatic bit m_fetching();
        return !m_boot && (m_buf.size() == 0);
    endfunction

    task automatic m_reset();
        m_pc   = 16'h0000;
        m_pend = 16'h0000;
        m_sq   = 1'b0;
        m_boot = 1'b1;
        m_buf.delete();
    endtask

    // Called at a negedge: compare outputs, advance the model with the inputs
    // that the next posedge will sample, then move to the following negedge.
    task automatic step();
        pkt_t p;
        check("req", 32'(imem_req), 32'(m_fetching()));
        check("addr", 32'(imem_addr), 32'(m_pc));
        check("valid", 32'(if_valid), 32'(m_buf.size() != 0));
        if (m_buf.size() != 0) begin
            check("instr", 32'(if_instr), 32'(m_buf[0].instr));
            check("ifpc", 32'(if_pc), 32'(m_buf[0].pc));
            seen_pc.push_back(if_pc);
            seen_instr.push_back(if_instr);
        end

        if (m_boot) begin
            m_boot = 1'b0;
        end else if (m_buf.size() == 0) begin
            if (imem_ack) begin
                if (redirect) begin
                    m_pc = m_target();
                    m_sq = 1'b0;
                end else if (m_sq) begin
                    m_pc = m_pend;
                    m_sq = 1'b0;
                end else begin
                    p.pc    = m_pc;
                    p.instr = imem_data;
                    m_buf.push_back(p);
                    m_pc = m_pc + 16'd1;
                end
            end else if (redirect) begin
                m_pend = m_target();
                m_sq   = 1'b1;
            end
        end else begin
            if (redirect) begin
                m_buf.delete();
                m_pc = m_target();
            end else if (if_ready) begin
                void'(m_buf.pop_front());
            end
        end

        @(posedge clk);
        @(negedge clk);
        imem_ack = 1'b0;
        redirect = 1'b0;
    endtask

    task automatic ack_step();
        imem_ack  = 1'b1;
        imem_data = 16'h1000 + imem_addr;
        step();
    endtask

    task automatic set_redir(input logic [1:0] src, input logic [15:0] rpc,
                             input logic [15:0] off, input logic [11:0] jt,
                             input logic [15:0] jra);
        redirect    = 1'b1;
        pc_src      = src;
        redirect_pc = rpc;
        br_offset   = off;
        j_target    = jt;
        jr_addr     = jra;
    endtask

    // Entered at a negedge; asserts reset between edges and leaves at a negedge in BOOT.
    task automatic mid_reset();
        #2;
        reset     = 1'b1;
        imem_ack  = 1'b1;
        imem_data = 16'hDEAD;
        #1;
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(if_valid), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'h0000);
        check("rst_instr", 32'(if_instr), 32'h0000);
        check("rst_ifpc", 32'(if_pc), 32'h0000);
        @(posedge clk);
        @(negedge clk);
        reset    = 1'b0;
        imem_ack = 1'b0;
        m_reset();
    endtask

    initial begin
        reset = 1'b1;
        imem_ack = 1'b0; imem_data = '0; if_ready = 1'b0;
        redirect = 1'b0; pc_src = '0; redirect_pc = '0; br_offset = '0;
        j_target = '0; jr_addr = '0;
        #1;
        check("init_req", 32'(imem_req), 32'd0);
        check("init_valid", 32'(if_valid), 32'd0);
        check("init_instr", 32'(if_instr), 32'h0000);
        check("init_ifpc", 32'(if_pc), 32'h0000);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_reset();

        // Sequential run with zero-wait memory and decode always ready
        for (int i = 0; i < 7; i++) begin
            imem_ack  = imem_req;
            imem_data = 16'h1000 + imem_addr;
            if_ready  = 1'b1;
            step();
        end
        check("seq_count", 32'(seen_pc.size()), 32'd3);
        check("seq_pc0", 32'(seen_pc[0]), 32'h0000);
        check("seq_pc1", 32'(seen_pc[1]), 32'h0001);
        check("seq_pc2", 32'(seen_pc[2]), 32'h0002);
        check("seq_in0", 32'(seen_instr[0]), 32'h1000);
        check("seq_in1", 32'(seen_instr[1]), 32'h1001);
        check("seq_in2", 32'(seen_instr[2]), 32'h1002);

        // Backpressure
        if_ready = 1'b0;
        ack_step();
        for (int i = 0; i < 5; i++) begin
            check("bp_req", 32'(imem_req), 32'd0);
            check("bp_pc", 32'(if_pc), 32'h0003);
            check("bp_instr", 32'(if_instr), 32'h1003);
            step();
        end
        if_ready = 1'b1;
        step();
        if_ready = 1'b0;
        check("bp_next_req", 32'(imem_req), 32'd1);
        check("bp_next_addr", 32'(imem_addr), 32'h0004);

        // Branch, jump and jump-register targets, each redirected from VALID
        ack_step();
        set_redir(2'b01, 16'h0010, 16'hFFFC, 12'h000, 16'h0000);
        step();
        check("branch_addr", 32'(imem_addr), 32'h000D);
        ack_step();
        set_redir(2'b10, 16'h3FFF, 16'h0000, 12'h123, 16'h0000);
        step();
        check("jump_addr", 32'(imem_addr), 32'h4123);
        ack_step();
        set_redir(2'b11, 16'h0000, 16'h0000, 12'h000, 16'hABCD);
        step();
        check("jr_addr", 32'(imem_addr), 32'hABCD);

        // Redirects during a four-cycle wait state; last one wins
        set_redir(2'b11, 16'h0000, 16'h0000, 12'h000, 16'h0040);
        step();
        check("wait_addr1", 32'(imem_addr), 32'hABCD);
        set_redir(2'b11, 16'h0000, 16'h0000, 12'h000, 16'h0080);
        step();
        check("wait_addr2", 32'(imem_addr), 32'hABCD);
        step();
        check("wait_addr3", 32'(imem_addr), 32'hABCD);
        ack_step();
        check("wait_squash", 32'(if_valid), 32'd0);
        check("wait_next", 32'(imem_addr), 32'h0080);

        // Ack and redirect in the same cycle
        imem_ack  = 1'b1;
        imem_data = 16'h5555;
        set_redir(2'b11, 16'h0000, 16'h0000, 12'h000, 16'h0200);
        step();
        check("same_valid", 32'(if_valid), 32'd0);
        check("same_addr", 32'(imem_addr), 32'h0200);

        // Wrap-around from FFFF
        ack_step();
        set_redir(2'b11, 16'h0000, 16'h0000, 12'h000, 16'hFFFF);
        step();
        ack_step();
        check("wrap_ifpc", 32'(if_pc), 32'hFFFF);
        if_ready = 1'b1;
        step();
        if_ready = 1'b0;
        check("wrap_addr", 32'(imem_addr), 32'h0000);

        // Reset while a request is outstanding, then an ack in the BOOT cycle
        check("pre_rst_req", 32'(imem_req), 32'd1);
        mid_reset();
        imem_ack  = 1'b1;
        imem_data = 16'hBEEF;
        step();
        check("boot_ack_valid", 32'(if_valid), 32'd0);
        check("boot_ack_addr", 32'(imem_addr), 32'h0000);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if (i % 700 == 350) mid_reset();
            imem_ack  = imem_req && ($urandom_range(0, 2) != 0);
            imem_data = 16'($urandom);
            if_ready  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0)
                set_redir(2'($urandom), 16'($urandom), 16'($urandom),
                          12'($urandom), 16'($urandom));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
